// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive sequencer: line sync, mid-bit tick scheduler, frame FIFO
//
// Purpose:
//   Re-times the raw rx line, schedules mid-bit baud ticks for the receiver
//   FSM, and buffers completed frames {frame_err, parity_err, byte} in a
//   small FIFO drained by the host with a valid/ready handshake.
//
// Optional feature macro: UART_RX_DROP_ERR_EN
//   defined   : errored frames are not stored; err_cnt_o counts them (saturating)
//   undefined : errored frames are stored with their flags; err_cnt_o = 0
//
// Ports:
//   clk, nrst              clock (rising edge), asynchronous active-low reset
//   enable_i               receiver enable
//   rx_i                   raw serial line (idle high, asynchronous)
//   baud_div_i             clk cycles per bit (values below 2 act as 2)
//   parity_en_i            frame carries a parity bit
//   rx_sync_o              synchronized line for the receiver FSM
//   baud_tick_o            one-cycle mid-bit sample strobe
//   data_ready_i           receiver frame-complete strobe
//   rx_byte_i              received byte
//   parity_err_i           parity error flag
//   frame_err_i            stop-bit error flag
//   rd_valid_o             FIFO not empty
//   rd_data_o              {frame_err, parity_err, byte} at FIFO head, 0 when empty
//   rd_ready_i             host pop request
//   fifo_count_o           FIFO occupancy
//   overrun_o              sticky frame-dropped-on-full flag
//   clr_ovr_i              clears overrun_o
//   err_cnt_o              dropped errored frame count

module uart_rx_ctrl #(
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic                          enable_i,
  input  logic                          rx_i,
  input  logic [DIV_W-1:0]              baud_div_i,
  input  logic                          parity_en_i,
  output logic                          rx_sync_o,
  output logic                          baud_tick_o,
  input  logic                          data_ready_i,
  input  logic [7:0]                    rx_byte_i,
  input  logic                          parity_err_i,
  input  logic                          frame_err_i,
  output logic                          rd_valid_o,
  output logic [9:0]                    rd_data_o,
  input  logic                          rd_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
  output logic                          overrun_o,
  input  logic                          clr_ovr_i,
  output logic [7:0]                    err_cnt_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_HUNT, S_HALF, S_BITS} state_t;

  // ---------------- synchronizer ----------------
  logic r_sync1, r_sync2, r_sync3;
  logic w_fall;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_sync3 <= 1'b1;
    end else begin
      r_sync1 <= rx_i;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign rx_sync_o = r_sync2;
  assign w_fall    = r_sync3 & ~r_sync2;

  // ---------------- tick scheduler ----------------
  state_t           r_state;
  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_div;
  logic [3:0]       r_tick_cnt;
  logic             r_par;
  logic [DIV_W-1:0] w_div_sel;
  logic             w_cnt_zero;
  logic             w_active;
  logic             w_last;

  assign w_div_sel  = (baud_div_i < DIV_W'(2)) ? DIV_W'(2) : baud_div_i;
  assign w_cnt_zero = (r_cnt == '0);
  assign w_active   = (r_state == S_HALF) || (r_state == S_BITS);
  // tick_cnt still holds the count before this tick: 9 -> 10th tick, 10 -> 11th
  assign w_last     = (r_tick_cnt == (r_par ? 4'd10 : 4'd9));

  // Decoded from registered state/counter; gated by enable_i so a disable
  // suppresses a tick falling in the same cycle.
  assign baud_tick_o = enable_i & w_active & w_cnt_zero;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_div      <= DIV_W'(2);
      r_tick_cnt <= '0;
      r_par      <= 1'b0;
    end else if (!enable_i) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_tick_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: r_state <= S_HUNT;
        S_HUNT: begin
          if (w_fall) begin
            r_div   <= w_div_sel;
            r_cnt   <= (w_div_sel >> 1) - DIV_W'(1);
            r_par   <= parity_en_i;
            r_state <= S_HALF;
          end
        end
        S_HALF: begin
          if (w_cnt_zero) begin
            r_cnt      <= r_div - DIV_W'(1);
            r_tick_cnt <= 4'd1;
            // line back high at the start-bit centre: treat as a glitch
            r_state    <= rx_sync_o ? S_HUNT : S_BITS;
          end else begin
            r_cnt <= r_cnt - DIV_W'(1);
          end
        end
        S_BITS: begin
          if (w_cnt_zero) begin
            r_cnt      <= r_div - DIV_W'(1);
            r_tick_cnt <= r_tick_cnt + 4'd1;
            if (w_last) r_state <= S_HUNT;
          end else begin
            r_cnt <= r_cnt - DIV_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // ---------------- receive FIFO ----------------
  logic [9:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_ovr;
  logic          w_push_req, w_push, w_pop, w_full, w_ovr_set;
  logic [9:0]    w_wdata;

`ifdef UART_RX_DROP_ERR_EN
  logic       w_err;
  logic [7:0] r_err_cnt;

  assign w_err      = parity_err_i | frame_err_i;
  assign w_push_req = data_ready_i & ~w_err;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_err_cnt <= '0;
    end else if (data_ready_i && w_err && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign err_cnt_o = r_err_cnt;
`else
  assign w_push_req = data_ready_i;
  assign err_cnt_o  = '0;
`endif

  assign w_wdata   = {frame_err_i, parity_err_i, rx_byte_i};
  assign w_full    = (r_count == CW'(FIFO_DEPTH));
  assign w_pop     = (r_count != '0) & rd_ready_i;
  // a pop frees the slot the push needs, so full+push+pop is lossless
  assign w_push    = w_push_req & (~w_full | w_pop);
  assign w_ovr_set = w_push_req & w_full & ~w_pop;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovr    <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_wdata;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_ovr_set)      r_ovr <= 1'b1;
      else if (clr_ovr_i) r_ovr <= 1'b0;
    end
  end

  assign rd_valid_o   = (r_count != '0);
  assign rd_data_o    = rd_valid_o ? r_mem[r_rd_ptr] : 10'd0;
  assign fifo_count_o = r_count;
  assign overrun_o    = r_ovr;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - self-checking bench for uart_rx_ctrl
module tb_uart_rx_ctrl;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        nrst, enable_i, rx_i, parity_en_i, rd_ready_i, clr_ovr_i;
  logic [15:0] baud_div_i;
  logic        rx_sync_o, baud_tick_o, rd_valid_o, overrun_o;
  logic [9:0]  rd_data_o;
  logic [2:0]  fifo_count_o;
  logic [7:0]  err_cnt_o;
  logic        data_ready_i, parity_err_i, frame_err_i;
  logic [7:0]  rx_byte_i;

  logic        drv_ready, drv_perr, drv_ferr;
  logic [7:0]  drv_byte;
  logic        rxm_ready, rxm_perr, rxm_ferr;
  logic [7:0]  rxm_byte;

  assign data_ready_i = drv_ready | rxm_ready;
  assign rx_byte_i    = rxm_ready ? rxm_byte : drv_byte;
  assign parity_err_i = rxm_ready ? rxm_perr : drv_perr;
  assign frame_err_i  = rxm_ready ? rxm_ferr : drv_ferr;

  uart_rx_ctrl #(.DIV_W(16), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .nrst(nrst), .enable_i(enable_i), .rx_i(rx_i),
    .baud_div_i(baud_div_i), .parity_en_i(parity_en_i),
    .rx_sync_o(rx_sync_o), .baud_tick_o(baud_tick_o),
    .data_ready_i(data_ready_i), .rx_byte_i(rx_byte_i),
    .parity_err_i(parity_err_i), .frame_err_i(frame_err_i),
    .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o), .rd_ready_i(rd_ready_i),
    .fifo_count_o(fifo_count_o), .overrun_o(overrun_o),
    .clr_ovr_i(clr_ovr_i), .err_cnt_o(err_cnt_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int         cyc = 0;
  logic       m_s1, m_s2, m_ovr;
  logic [9:0] mq[$];
  int         m_err;
  bit         exp_tick[int];
  bit         m_push, m_pop, m_full, m_errf;

  always @(posedge clk) cyc++;

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      m_s1 = 1'b1; m_s2 = 1'b1; mq.delete(); m_ovr = 1'b0; m_err = 0;
    end else begin
      m_s2   = m_s1;
      m_s1   = rx_i;
      m_errf = parity_err_i | frame_err_i;
`ifdef UART_RX_DROP_ERR_EN
      m_push = data_ready_i && !m_errf;
      if (data_ready_i && m_errf && m_err < 255) m_err++;
`else
      m_push = data_ready_i;
`endif
      m_pop  = (mq.size() > 0) && rd_ready_i;
      m_full = (mq.size() == DEPTH);
      if (m_push && m_full && !m_pop) m_ovr = 1'b1;
      else if (clr_ovr_i)              m_ovr = 1'b0;
      if (m_pop) void'(mq.pop_front());
      if (m_push && (!m_full || m_pop)) mq.push_back({frame_err_i, parity_err_i, rx_byte_i});
    end
  end

  always @(negedge clk) begin
    if (nrst) begin
      chk("rx_sync", rx_sync_o, m_s2);
      chk("baud_tick", baud_tick_o, exp_tick.exists(cyc));
      chk("rd_valid", rd_valid_o, mq.size() != 0);
      chk("rd_data", rd_data_o, (mq.size() != 0) ? mq[0] : 10'd0);
      chk("fifo_count", fifo_count_o, mq.size());
      chk("overrun", overrun_o, m_ovr);
      chk("err_cnt", err_cnt_o, m_err);
    end
  end

  // ---------------- tick monitor + stand-in receiver FSM ----------------
  int          tick_seen, tick_first, tick_last, rxm_n;
  logic [10:0] rxm_bits;
  bit          rxm_pend;

  initial begin
    rxm_ready = 0; rxm_byte = 0; rxm_perr = 0; rxm_ferr = 0;
    rxm_pend = 0; rxm_n = 0; rxm_bits = '0;
    tick_seen = 0; tick_first = 0; tick_last = 0;
    forever begin
      @(posedge clk); #2;
      rxm_ready = rxm_pend;
      rxm_pend  = 0;
      @(negedge clk);
      if (baud_tick_o) begin
        if (tick_seen == 0) tick_first = cyc;
        tick_last = cyc;
        tick_seen++;
      end
      if (!nrst || !enable_i) begin
        rxm_n = 0; rxm_pend = 0;
      end else if (baud_tick_o) begin
        rxm_bits[rxm_n] = rx_sync_o;
        rxm_n++;
        if (rxm_n == 1 && rx_sync_o) rxm_n = 0;
        else if (rxm_n == (parity_en_i ? 11 : 10)) begin
          rxm_byte = rxm_bits[8:1];
          rxm_perr = parity_en_i ? ^rxm_bits[9:1] : 1'b0;
          rxm_ferr = ~rxm_bits[rxm_n-1];
          rxm_pend = 1;
          rxm_n    = 0;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  int start_cyc;

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  // Drives one frame on rx_i; records ticks expected at edge-detect + div/2 + k*div
  task automatic send_frame(input logic [7:0] b, input bit par, input bit stop, input int keep);
    int d, len;
    logic [10:0] bits;
    d    = (baud_div_i < 2) ? 2 : int'(baud_div_i);
    len  = par ? 11 : 10;
    bits = par ? {stop, ^b, b, 1'b0} : {1'b1, stop, b, 1'b0};
    start_cyc = cyc;
    for (int k = 0; k < keep; k++) exp_tick[cyc + 2 + d/2 + k*d] = 1;
    for (int i = 0; i < len; i++) begin
      rx_i = bits[i];
      step(d);
    end
    rx_i = 1'b1;
  endtask

  task automatic push_word(input logic [9:0] w);
    drv_ready = 1; drv_byte = w[7:0]; drv_perr = w[8]; drv_ferr = w[9];
    step(1);
    drv_ready = 0;
  endtask

  task automatic pop_word(output logic [9:0] w);
    rd_ready_i = 1;
    @(negedge clk);
    w = rd_data_o;
    step(1);
    rd_ready_i = 0;
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_rx_sync"}, rx_sync_o, 1);
    chk({p, "_tick"}, baud_tick_o, 0);
    chk({p, "_valid"}, rd_valid_o, 0);
    chk({p, "_data"}, rd_data_o, 0);
    chk({p, "_count"}, fifo_count_o, 0);
    chk({p, "_ovr"}, overrun_o, 0);
    chk({p, "_errcnt"}, err_cnt_o, 0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [9:0] w;
  logic [9:0] exp_drain [4];

  initial begin
    nrst = 0; enable_i = 0; rx_i = 1; baud_div_i = 16; parity_en_i = 0;
    rd_ready_i = 0; clr_ovr_i = 0; drv_ready = 0; drv_byte = 0; drv_perr = 0; drv_ferr = 0;
    step(3);
    @(negedge clk);
    chk_reset("reset");
    step(1);
    nrst = 1;
    step(2);
    enable_i = 1;
    step(4);

    // div=16, no parity, 0xA5
    tick_seen = 0;
    send_frame(8'hA5, 0, 1, 10);
    step(6);
    chk("t1_first_delay", tick_first - start_cyc, 10);
    chk("t1_ticks", tick_seen, 10);
    chk("t1_span", tick_last - tick_first, 144);
    chk("t1_data", rd_data_o, 10'h0A5);
    chk("t1_count", fifo_count_o, 1);

    // 4-cycle low glitch: one tick, false start, no push
    tick_seen = 0;
    exp_tick[cyc + 10] = 1;
    rx_i = 0; step(4); rx_i = 1; step(40);
    chk("t2_ticks", tick_seen, 1);
    chk("t2_count", fifo_count_o, 1);

    // div=1 behaves as div=2
    baud_div_i = 1; tick_seen = 0;
    send_frame(8'h3C, 0, 1, 10);
    step(6);
    chk("div1_first_delay", tick_first - start_cyc, 3);
    chk("div1_ticks", tick_seen, 10);
    chk("div1_span", tick_last - tick_first, 18);
    chk("div1_count", fifo_count_o, 2);

    // parity frame, div=8: 11 ticks
    baud_div_i = 8; parity_en_i = 1; tick_seen = 0;
    send_frame(8'h5A, 1, 1, 11);
    step(6);
    chk("par_first_delay", tick_first - start_cyc, 6);
    chk("par_ticks", tick_seen, 11);
    chk("par_count", fifo_count_o, 3);
    parity_en_i = 0; baud_div_i = 16;

    // frame error
    send_frame(8'h81, 0, 0, 10);
    step(6);
`ifdef UART_RX_DROP_ERR_EN
    chk("ferr_count", fifo_count_o, 3);
    chk("ferr_errcnt", err_cnt_o, 1);
`else
    chk("ferr_count", fifo_count_o, 4);
`endif
    pop_word(w); chk("drain_a5", w, 10'h0A5);
    pop_word(w); chk("drain_3c", w, 10'h03C);
    pop_word(w); chk("drain_5a", w, 10'h05A);
`ifndef UART_RX_DROP_ERR_EN
    chk("ferr_head", rd_data_o, 10'h281);
    pop_word(w);
`endif
    chk("drained_count", fifo_count_o, 0);

    // enable dropped at the 4th tick cycle
    push_word(10'h0EE);
    tick_seen = 0;
    fork
      send_frame(8'h77, 0, 1, 3);
      begin step(58); enable_i = 0; end
    join
    chk("dis_ticks", tick_seen, 3);
    chk("dis_count", fifo_count_o, 1);
    chk("dis_head", rd_data_o, 10'h0EE);
    enable_i = 1;
    step(4);
    tick_seen = 0;
    send_frame(8'hC3, 0, 1, 10);
    step(6);
    chk("reen_ticks", tick_seen, 10);
    chk("reen_count", fifo_count_o, 2);
    pop_word(w); chk("reen_pop0", w, 10'h0EE);
    pop_word(w); chk("reen_pop1", w, 10'h0C3);

    // overflow and overrun flag
    push_word(10'h011); push_word(10'h022); push_word(10'h033);
    push_word(10'h044); push_word(10'h055);
    chk("ovf_count", fifo_count_o, 4);
    chk("ovf_flag", overrun_o, 1);
    chk("ovf_head", rd_data_o, 10'h011);
    clr_ovr_i = 1; step(1); clr_ovr_i = 0;
    chk("clr_flag", overrun_o, 0);
    chk("clr_head", rd_data_o, 10'h011);
    chk("clr_count", fifo_count_o, 4);
    clr_ovr_i = 1; push_word(10'h066); clr_ovr_i = 0;
    chk("setwins_flag", overrun_o, 1);
    clr_ovr_i = 1; step(1); clr_ovr_i = 0;

    // full + push + pop in the same cycle
    rd_ready_i = 1; push_word(10'h077); rd_ready_i = 0;
    chk("fpp_count", fifo_count_o, 4);
    chk("fpp_ovr", overrun_o, 0);
    chk("fpp_head", rd_data_o, 10'h022);
    exp_drain[0] = 10'h022; exp_drain[1] = 10'h033;
    exp_drain[2] = 10'h044; exp_drain[3] = 10'h077;
    for (int i = 0; i < 4; i++) begin
      pop_word(w);
      chk($sformatf("fpp_drain%0d", i), w, exp_drain[i]);
    end
    for (int i = 0; i < 8; i++) begin
      push_word({2'b00, 8'(i * 37 + 5)});
      pop_word(w);
      chk($sformatf("wrap%0d", i), w, {2'b00, 8'(i * 37 + 5)});
    end
    chk("wrap_count", fifo_count_o, 0);

    // reset asserted mid-frame
    push_word(10'h012);
    fork
      send_frame(8'h96, 0, 1, 10);
      begin
        step(30);
        nrst = 0; enable_i = 0;
        exp_tick.delete();
        @(negedge clk);
        chk_reset("midrst");
      end
    join
    nrst = 1;
    step(2);
    enable_i = 1;
    step(4);
    send_frame(8'hE1, 0, 1, 10);
    step(6);
    chk("post_rst_count", fifo_count_o, 1);
    chk("post_rst_head", rd_data_o, 10'h0E1);

    step(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
